// File: rtl/inst_decoder.sv
// RV32I decode stage: splits each instruction into fields, a sign-extended immediate
// and ALU / memory / branch control bundles, registered with a latency of cycleNum clocks.
module inst_decoder #(
  parameter int unsigned cycleNum = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iInst,
  input  logic [31:0] iCurPC,
  input  logic        iFlushPipe,
  output logic [4:0]  oRs1Addr,
  output logic [4:0]  oRs2Addr,
  output logic [4:0]  oRdAddr,
  output logic [2:0]  oF3,
  output logic [6:0]  oF7,
  output logic [31:0] oImm,
  output logic [6:0]  oOpcode,
  output logic [31:0] oCurPc,
  output logic        oLoad,
  output logic        oStore,
  output logic        oMemDv,
  output logic [3:0]  oAritType,
  output logic        oOpRs1,
  output logic        oOpRs2,
  output logic        oOpImm,
  output logic        oOpPc,
  output logic        oOpConst,
  output logic        oOpDv,
  output logic [3:0]  oBrOp,
  output logic        oBrDv
);

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [XLEN-1:0] pc;
    logic            load;
    logic            store;
    logic            mem_dv;
    logic [3:0]      arit;
    logic            op_rs1;
    logic            op_rs2;
    logic            op_imm;
    logic            op_pc;
    logic            op_const;
    logic            op_dv;
    logic [3:0]      br_op;
    logic            br_dv;
  } dec_t;

  logic [XLEN-1:0] dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic            dec_vld;

  // Optional input stage; a flush kills the instruction sampled on that edge.
  if (cycleNum == 2) begin : g_stage1
    logic [XLEN-1:0] inst_d, inst_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic            vld_d, vld_q;

    always_comb begin
      inst_d = iInst;
      pc_d   = iCurPC;
      vld_d  = ~iFlushPipe;
    end

    always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
        inst_q <= '0;
        pc_q   <= '0;
        vld_q  <= 1'b0;
      end else begin
        inst_q <= inst_d;
        pc_q   <= pc_d;
        vld_q  <= vld_d;
      end
    end

    assign dec_inst = inst_q;
    assign dec_pc   = pc_q;
    assign dec_vld  = vld_q;
  end else begin : g_bypass
    assign dec_inst = iInst;
    assign dec_pc   = iCurPC;
    assign dec_vld  = 1'b1;
  end

  logic [6:0]      opc;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  always_comb begin
    opc   = dec_inst[6:0];
    imm_i = {{20{dec_inst[31]}}, dec_inst[31:20]};
    imm_s = {{20{dec_inst[31]}}, dec_inst[31:25], dec_inst[11:7]};
    imm_b = {{19{dec_inst[31]}}, dec_inst[31], dec_inst[7], dec_inst[30:25],
             dec_inst[11:8], 1'b0};
    imm_u = {dec_inst[31:12], 12'b0};
    imm_j = {{11{dec_inst[31]}}, dec_inst[31], dec_inst[19:12], dec_inst[20],
             dec_inst[30:21], 1'b0};
  end

  dec_t dec_d, dec_q;

  // Per-opcode field selection and control bundles.
  always_comb begin
    dec_d        = '0;
    dec_d.opcode = opc;
    dec_d.pc     = dec_pc;
    case (opc)
      OPC_OP: begin
        dec_d.rs1    = dec_inst[19:15];
        dec_d.rs2    = dec_inst[24:20];
        dec_d.rd     = dec_inst[11:7];
        dec_d.f3     = dec_inst[14:12];
        dec_d.f7     = dec_inst[31:25];
        dec_d.arit   = {dec_inst[30], dec_inst[14:12]};
        dec_d.op_rs1 = 1'b1;
        dec_d.op_rs2 = 1'b1;
        dec_d.op_dv  = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_d.rs1    = dec_inst[19:15];
        dec_d.rd     = dec_inst[11:7];
        dec_d.f3     = dec_inst[14:12];
        dec_d.imm    = imm_i;
        // Only shift-immediates carry a funct7 (and the SRA/SRL selector).
        if (dec_inst[13:12] == 2'b01) dec_d.f7 = dec_inst[31:25];
        dec_d.arit   = {(dec_inst[14:12] == 3'b101) & dec_inst[30], dec_inst[14:12]};
        dec_d.op_rs1 = 1'b1;
        dec_d.op_imm = 1'b1;
        dec_d.op_dv  = 1'b1;
      end
      OPC_LOAD: begin
        dec_d.rs1    = dec_inst[19:15];
        dec_d.rd     = dec_inst[11:7];
        dec_d.f3     = dec_inst[14:12];
        dec_d.imm    = imm_i;
        dec_d.load   = 1'b1;
        dec_d.mem_dv = 1'b1;
      end
      OPC_JALR: begin
        dec_d.rs1      = dec_inst[19:15];
        dec_d.rd       = dec_inst[11:7];
        dec_d.f3       = dec_inst[14:12];
        dec_d.imm      = imm_i;
        dec_d.op_pc    = 1'b1;
        dec_d.op_const = 1'b1;
        dec_d.op_dv    = 1'b1;
        dec_d.br_op    = 4'b1001;
        dec_d.br_dv    = 1'b1;
      end
      OPC_STORE: begin
        dec_d.rs1    = dec_inst[19:15];
        dec_d.rs2    = dec_inst[24:20];
        dec_d.f3     = dec_inst[14:12];
        dec_d.imm    = imm_s;
        dec_d.store  = 1'b1;
        dec_d.mem_dv = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.rs1   = dec_inst[19:15];
        dec_d.rs2   = dec_inst[24:20];
        dec_d.f3    = dec_inst[14:12];
        dec_d.imm   = imm_b;
        dec_d.br_op = {1'b0, dec_inst[14:12]};
        dec_d.br_dv = 1'b1;
      end
      OPC_LUI: begin
        dec_d.rd     = dec_inst[11:7];
        dec_d.imm    = imm_u;
        dec_d.op_imm = 1'b1;
        dec_d.op_dv  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.rd     = dec_inst[11:7];
        dec_d.imm    = imm_u;
        dec_d.op_pc  = 1'b1;
        dec_d.op_imm = 1'b1;
        dec_d.op_dv  = 1'b1;
      end
      OPC_JAL: begin
        dec_d.rd       = dec_inst[11:7];
        dec_d.imm      = imm_j;
        dec_d.op_pc    = 1'b1;
        dec_d.op_const = 1'b1;
        dec_d.op_dv    = 1'b1;
        dec_d.br_op    = 4'b1000;
        dec_d.br_dv    = 1'b1;
      end
      default: begin
        dec_d.rs1 = dec_inst[19:15];
        dec_d.rs2 = dec_inst[24:20];
        dec_d.rd  = dec_inst[11:7];
        dec_d.f3  = dec_inst[14:12];
        dec_d.f7  = dec_inst[31:25];
      end
    endcase
    // Killed slots keep their fields but never present a valid bundle.
    if (!dec_vld || iFlushPipe) begin
      dec_d.load   = 1'b0;
      dec_d.store  = 1'b0;
      dec_d.mem_dv = 1'b0;
      dec_d.op_dv  = 1'b0;
      dec_d.br_dv  = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) dec_q <= '0;
    else       dec_q <= dec_d;
  end

  assign oRs1Addr  = dec_q.rs1;
  assign oRs2Addr  = dec_q.rs2;
  assign oRdAddr   = dec_q.rd;
  assign oF3       = dec_q.f3;
  assign oF7       = dec_q.f7;
  assign oImm      = dec_q.imm;
  assign oOpcode   = dec_q.opcode;
  assign oCurPc    = dec_q.pc;
  assign oLoad     = dec_q.load;
  assign oStore    = dec_q.store;
  assign oMemDv    = dec_q.mem_dv;
  assign oAritType = dec_q.arit;
  assign oOpRs1    = dec_q.op_rs1;
  assign oOpRs2    = dec_q.op_rs2;
  assign oOpImm    = dec_q.op_imm;
  assign oOpPc     = dec_q.op_pc;
  assign oOpConst  = dec_q.op_const;
  assign oOpDv     = dec_q.op_dv;
  assign oBrOp     = dec_q.br_op;
  assign oBrDv     = dec_q.br_dv;

endmodule

// File: tb/tb_inst_decoder.sv
// Scoreboard bench for inst_decoder: a driver pushes hand-decoded expectations,
// a negedge monitor pops and compares them when each instruction reaches the outputs.
module tb_inst_decoder;

  localparam int unsigned LAT  = 2;
  localparam int unsigned NVEC = 15;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [6:0]  opc;
    logic [31:0] pc;
    logic        ld;
    logic        st;
    logic        mdv;
    logic [3:0]  arit;
    logic [5:0]  sel;   // {OpRs1, OpRs2, OpImm, OpPc, OpConst, OpDv}
    logic [3:0]  brop;
    logic        brdv;
  } out_t;

  typedef struct packed {
    out_t        exp;
    logic        kill;
    logic [31:0] tag;
    logic [31:0] id;
  } ent_t;

  logic        iClk, iRst, iFlushPipe;
  logic [31:0] iInst, iCurPC;
  logic [4:0]  oRs1Addr, oRs2Addr, oRdAddr;
  logic [2:0]  oF3;
  logic [6:0]  oF7, oOpcode;
  logic [31:0] oImm, oCurPc;
  logic        oLoad, oStore, oMemDv, oOpRs1, oOpRs2, oOpImm, oOpPc, oOpConst, oOpDv, oBrDv;
  logic [3:0]  oAritType, oBrOp;

  inst_decoder #(.cycleNum(LAT)) dut (
    .iClk(iClk), .iRst(iRst), .iInst(iInst), .iCurPC(iCurPC), .iFlushPipe(iFlushPipe),
    .oRs1Addr(oRs1Addr), .oRs2Addr(oRs2Addr), .oRdAddr(oRdAddr), .oF3(oF3), .oF7(oF7),
    .oImm(oImm), .oOpcode(oOpcode), .oCurPc(oCurPc), .oLoad(oLoad), .oStore(oStore),
    .oMemDv(oMemDv), .oAritType(oAritType), .oOpRs1(oOpRs1), .oOpRs2(oOpRs2),
    .oOpImm(oOpImm), .oOpPc(oOpPc), .oOpConst(oOpConst), .oOpDv(oOpDv),
    .oBrOp(oBrOp), .oBrDv(oBrDv)
  );

  out_t got;
  assign got = {oRs1Addr, oRs2Addr, oRdAddr, oF3, oF7, oImm, oOpcode, oCurPc,
                oLoad, oStore, oMemDv, oAritType,
                oOpRs1, oOpRs2, oOpImm, oOpPc, oOpConst, oOpDv, oBrOp, oBrDv};

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int unsigned cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  ent_t        sb_q[$];

  logic [31:0] vin[NVEC];
  logic [31:0] vpc[NVEC];
  out_t        vexp[NVEC];

  function automatic out_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [6:0] opc, input logic [31:0] pc,
                              input logic [2:0] mem, input logic [3:0] arit,
                              input logic [5:0] sel, input logic [3:0] brop,
                              input logic brdv);
    out_t o;
    o = '{rs1, rs2, rd, f3, f7, imm, opc, pc, mem[2], mem[1], mem[0], arit, sel, brop, brdv};
    return o;
  endfunction

  // Monitor: compare each entry on the cycle its instruction reaches the outputs.
  always @(negedge iClk) begin
    ent_t e;
    if (iRst) begin
      while (sb_q.size() > 0 && sb_q[0].tag + LAT - 1 <= cyc) begin
        e = sb_q.pop_front();
        vec_cnt++;
        if (e.tag + LAT - 1 < cyc) begin
          err_cnt++;
          $display("FAIL vec%0d late: cycle %0d, required %0d", e.id, cyc, e.tag + LAT - 1);
        end else if (e.kill) begin
          if ({got.ld, got.st, got.mdv, got.sel[0], got.brdv} != 5'b0) begin
            err_cnt++;
            $display("FAIL vec%0d flushed flags: got %b required 00000", e.id,
                     {got.ld, got.st, got.mdv, got.sel[0], got.brdv});
          end
        end else if (got != e.exp) begin
          err_cnt++;
          $display("FAIL vec%0d decode: got %h required %h", e.id, got, e.exp);
        end
      end
    end
  end

  task automatic step(input int unsigned idx, input logic flush);
    ent_t e;
    @(negedge iClk);
    iInst      = vin[idx];
    iCurPC     = vpc[idx];
    iFlushPipe = flush;
    @(posedge iClk);
    #1;
    e.exp  = vexp[idx];
    e.kill = flush;
    e.tag  = cyc;
    e.id   = idx;
    // A flush kills the instruction just sampled and every one still in flight.
    if (flush) begin
      for (int i = 0; i < sb_q.size(); i++) begin
        ent_t t;
        t = sb_q[i];
        if (t.tag + LAT > cyc) begin
          t.kill = 1'b1;
          sb_q[i] = t;
        end
      end
    end
    sb_q.push_back(e);
  endtask

  initial begin
    vin[0]  = 32'h002081B3; vpc[0]  = 32'h000;  // ADD x3,x1,x2
    vexp[0] = mk(1, 2, 3, 0, 0, 32'h0, 7'h33, 32'h000, 3'b000, 4'b0000, 6'b110001, 4'b0000, 0);
    vin[1]  = 32'hFFF00293; vpc[1]  = 32'h004;  // ADDI x5,x0,-1
    vexp[1] = mk(0, 0, 5, 0, 0, 32'hFFFFFFFF, 7'h13, 32'h004, 3'b000, 4'b0000, 6'b101001, 4'b0000, 0);
    vin[2]  = 32'h00812303; vpc[2]  = 32'h008;  // LW x6,8(x2)
    vexp[2] = mk(2, 0, 6, 2, 0, 32'h8, 7'h03, 32'h008, 3'b101, 4'b0000, 6'b000000, 4'b0000, 0);
    vin[3]  = 32'h00612623; vpc[3]  = 32'h00C;  // SW x6,12(x2)
    vexp[3] = mk(2, 6, 0, 2, 0, 32'hC, 7'h23, 32'h00C, 3'b011, 4'b0000, 6'b000000, 4'b0000, 0);
    vin[4]  = 32'h00208863; vpc[4]  = 32'h010;  // BEQ x1,x2,+16
    vexp[4] = mk(1, 2, 0, 0, 0, 32'h10, 7'h63, 32'h010, 3'b000, 4'b0000, 6'b000000, 4'b0000, 1);
    vin[5]  = 32'h008000EF; vpc[5]  = 32'h100;  // JAL x1,+8
    vexp[5] = mk(0, 0, 1, 0, 0, 32'h8, 7'h6F, 32'h100, 3'b000, 4'b0000, 6'b000111, 4'b1000, 1);
    vin[6]  = 32'h123453B7; vpc[6]  = 32'h104;  // LUI x7,0x12345
    vexp[6] = mk(0, 0, 7, 0, 0, 32'h12345000, 7'h37, 32'h104, 3'b000, 4'b0000, 6'b001001, 4'b0000, 0);
    vin[7]  = 32'h4030D213; vpc[7]  = 32'h108;  // SRAI x4,x1,3
    vexp[7] = mk(1, 0, 4, 5, 7'h20, 32'h403, 7'h13, 32'h108, 3'b000, 4'b1101, 6'b101001, 4'b0000, 0);
    vin[8]  = 32'h40418433; vpc[8]  = 32'h10C;  // SUB x8,x3,x4
    vexp[8] = mk(3, 4, 8, 0, 7'h20, 32'h0, 7'h33, 32'h10C, 3'b000, 4'b1000, 6'b110001, 4'b0000, 0);
    vin[9]  = 32'hFFFFF497; vpc[9]  = 32'h110;  // AUIPC x9,0xFFFFF
    vexp[9] = mk(0, 0, 9, 0, 0, 32'hFFFFF000, 7'h17, 32'h110, 3'b000, 4'b0000, 6'b001101, 4'b0000, 0);
    vin[10] = 32'h004280E7; vpc[10] = 32'h114;  // JALR x1,4(x5)
    vexp[10] = mk(5, 0, 1, 0, 0, 32'h4, 7'h67, 32'h114, 3'b000, 4'b0000, 6'b000111, 4'b1001, 1);
    vin[11] = 32'hFE20CEE3; vpc[11] = 32'h118;  // BLT x1,x2,-4
    vexp[11] = mk(1, 2, 0, 4, 0, 32'hFFFFFFFC, 7'h63, 32'h118, 3'b000, 4'b0000, 6'b000000, 4'b0100, 1);
    vin[12] = 32'h00000073; vpc[12] = 32'h11C;  // ECALL (unsupported)
    vexp[12] = mk(0, 0, 0, 0, 0, 32'h0, 7'h73, 32'h11C, 3'b000, 4'b0000, 6'b000000, 4'b0000, 0);
    vin[13] = 32'h0FF0000F; vpc[13] = 32'h120;  // FENCE (unsupported, raw fields pass)
    vexp[13] = mk(0, 31, 0, 0, 7'h07, 32'h0, 7'h0F, 32'h120, 3'b000, 4'b0000, 6'b000000, 4'b0000, 0);
    vin[14] = 32'h8005B513; vpc[14] = 32'h124;  // SLTIU x10,x11,-2048
    vexp[14] = mk(11, 0, 10, 3, 0, 32'hFFFFF800, 7'h13, 32'h124, 3'b000, 4'b0011, 6'b101001, 4'b0000, 0);

    iRst = 1'b0; iFlushPipe = 1'b0; iInst = 32'h002081B3; iCurPC = 32'h40;
    #23;
    vec_cnt++;
    if (got != '0) begin
      err_cnt++;
      $display("FAIL reset_hold: got %h required 0", got);
    end
    @(negedge iClk);
    iRst = 1'b1;

    for (int i = 0; i < NVEC; i++) step(i, 1'b0);
    for (int i = 0; i < NVEC; i++) step(i, i == 5);
    @(negedge iClk);
    iFlushPipe = 1'b0;

    for (int n = 0; n < 10 && sb_q.size() > 0; n++) @(posedge iClk);
    if (sb_q.size() > 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL drain: %0d entries pending, required 0", sb_q.size());
    end

    // Asynchronous reset must clear valid outputs without waiting for an edge.
    iInst = 32'h002081B3; iCurPC = 32'h200;
    repeat (3) @(posedge iClk);
    #2;
    iRst = 1'b0;
    #1;
    vec_cnt++;
    if (got != '0) begin
      err_cnt++;
      $display("FAIL async_reset: got %h required 0", got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
